// File: rtl/cacheline_adaptor.sv
// Cache-line to memory-burst adaptor: splits one line read/write-back into
// BEATS ascending beats on the memory bus and returns a one-cycle line response.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0]   buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    last_beat;
  logic [BURST_WIDTH-1:0]  cur_slice;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  // Constant-index slice mux keeps the beat select free of variable part-selects
  always_comb begin
    cur_slice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (cnt_q == CNT_W'(b)) cur_slice = buf_q[b*BURST_WIDTH +: BURST_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          addr_d  = address_i;
          buf_d   = line_i;
          cnt_d   = '0;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) buf_d[b*BURST_WIDTH +: BURST_WIDTH] = burst_i;
          end
          cnt_d = last_beat ? '0 : cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = last_beat ? '0 : cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side and cache-side handshakes are pure decodes of the registered state
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = (read_o || write_o) ? addr_q : '0;
  assign burst_o   = write_o ? cur_slice : '0;
  assign line_o    = buf_q;

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache controller, between the cache's physical-memory port and the burst-oriented physical memory.
- Converts one full-line cache request (read or write-back) into a sequence of BURST_WIDTH beats on the memory bus.
- Returns a single-cycle line-level response to the cache.
- Holds the assembled or outgoing line in an internal buffer for the whole transaction.

Parameters:
LINE_WIDTH, 256, cache line width in bits
BURST_WIDTH, 64, memory beat width in bits; LINE_WIDTH must be an integer multiple
ADDR_WIDTH, 32, physical address width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
line_i  in  LINE_WIDTH  write-back data from cache
line_o  out  LINE_WIDTH  assembled fill line to cache
address_i  in  ADDR_WIDTH  line address from cache (pmem address)
read_i  in  1  cache line-read request (cache pmem_read)
write_i  in  1  cache line-write request (cache pmem_write)
resp_o  out  1  line transaction complete (cache pmem_resp)
burst_i  in  BURST_WIDTH  read beat from memory
burst_o  out  BURST_WIDTH  write beat to memory
address_o  out  ADDR_WIDTH  address to memory, held for whole burst
read_o  out  1  memory burst read
write_o  out  1  memory burst write
resp_i  in  1  memory beat accepted/valid, one per beat

Behaviour:
- BEATS = LINE_WIDTH/BURST_WIDTH (4 by default). The beat counter is clog2(BEATS) bits wide and wraps to 0 after the last beat.
- Reset is asserted asynchronously when rst=0:
  - state=IDLE, counter=0, line buffer=0, address register=0.
  - All outputs are 0: resp_o, read_o, write_o, line_o, burst_o, address_o.
- The clock/reset requirement is fixed: one clock (clk); reset is asynchronous and active-low (rst).
- States are IDLE, READ, WRITE and DONE. read_o, write_o and resp_o are decoded from the registered state only.
- IDLE:
  - If write_i=1: latch address_i and line_i, counter=0, go to WRITE.
  - Else if read_i=1: latch address_i, counter=0, go to READ.
  - Write takes priority if both are high.
  - resp_i is ignored in IDLE.
- READ:
  - read_o=1 and address_o=latched address.
  - On each cycle with resp_i=1, store burst_i into buffer slice [counter*BURST_WIDTH +: BURST_WIDTH] and increment counter.
  - On the beat where counter==BEATS-1, go to DONE.
  - With resp_i=0, hold everything.
- WRITE:
  - write_o=1, address_o=latched address, burst_o=buffer slice[counter].
  - On resp_i=1, increment counter; at the last beat go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o=write_o=0; then IDLE.
- line_o always drives the buffer. It is valid in the DONE cycle and holds until the next transaction modifies it.
- The cache keeps its request high during the DONE cycle. The block returns to IDLE on the next edge and re-samples the request there. The cache deasserts after seeing resp_o, so no duplicate transaction occurs.
- Requests that drop or change mid-burst are ignored; the burst always completes. line_i and address_i are sampled only in IDLE.
- Latency with resp_i continuously high:
  - Request sampled at edge 0.
  - Beats complete at edges 1..BEATS.
  - resp_o high in cycle BEATS+1.
  - Total BEATS+2 cycles from request to resp_o.
- Beat order is ascending, low slice first. address_o is never incremented; memory handles burst addressing.
- Reset mid-burst aborts immediately to the reset state. No resp_o is produced for the aborted transaction.

Test Plan:
- Read fill:
  - Stimulus: address_i=0x0000_1000, read_i=1; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i.
  - Required: line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; read_o high 4 cycles; resp_o pulses once, 6 cycles after request.
- Write-back:
  - Stimulus: line_i = {0xDDDD.., 0xCCCC.., 0xBBBB.., 0xAAAA..}, write_i=1, address_i=0x0000_2040.
  - Required: burst_o = 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. in order; address_o=0x2040 constant; single resp_o.
- Wait states:
  - Stimulus: read with resp_i pattern 1,0,0,1,0,1,1.
  - Required: exactly 4 beats captured in order; counter and buffer unchanged on resp_i=0 cycles; resp_o one cycle after the 4th beat.
- Back-to-back write then read (dirty-miss sequence):
  - Stimulus: write_i held until resp_o, then read_i of a different address.
  - Required: no second write burst; read_o asserts only after one IDLE cycle; both responses single-cycle.
- Simultaneous request and spurious response:
  - Stimulus: read_i=write_i=1 in IDLE → WRITE taken. Separately, resp_i=1 in IDLE.
  - Required: the spurious resp_i causes no state or buffer change.
- Reset mid-read:
  - Stimulus: drive rst=0 asynchronously after 2 beats.
  - Required: read_o and resp_o drop to 0 immediately, line_o=0, state=IDLE; a subsequent full read completes correctly.
